// File: rtl/memory_scheduler_pkg.sv
// Shared types and constants for the multi-port memory scheduler.
// The request record is used for the per-port latches and the issued-request copy.
package memory_scheduler_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned AGE_W  = 4;
  localparam int unsigned OWN_W  = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  // Saturating age increment; a port never ages past the promotion threshold.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age,
                                               input logic [AGE_W-1:0] limit);
    return (age >= limit) ? limit : age + AGE_W'(1);
  endfunction

endpackage

// File: rtl/memory_scheduler_select.sv
// Winner selection: the lowest-index starved port first, otherwise the lowest-index pending port.
module memory_scheduler_select
  import memory_scheduler_pkg::*;
#(
  parameter int unsigned NPORT        = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic [NPORT-1:0]            pending_i,
  input  logic [NPORT-1:0][AGE_W-1:0] age_i,
  output logic [OWN_W-1:0]            winner_o,
  output logic                        any_o
);

  logic starved_found;

  // Scan downwards so that the lowest matching index is the last one written.
  always_comb begin : p_select
    winner_o      = '0;
    starved_found = 1'b0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (pending_i[i] && (age_i[i] == AGE_W'(STARVE_LIMIT))) begin
        winner_o      = OWN_W'(i);
        starved_found = 1'b1;
      end
    end
    if (!starved_found) begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (pending_i[i]) begin
          winner_o = OWN_W'(i);
        end
      end
    end
  end

  assign any_o = |pending_i;

endmodule

// File: rtl/memory_scheduler.sv
// Shares one single-outstanding memory port between NPORT latched requesters,
// with fixed priority plus aging, zero-cycle issue from IDLE and back-to-back issue on completion.
module memory_scheduler
  import memory_scheduler_pkg::*;
#(
  parameter int unsigned NPORT        = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_instr,
  input  logic [ADDR_W*NPORT-1:0] req_addr,
  input  logic [DATA_W*NPORT-1:0] req_wdata,
  input  logic [STRB_W*NPORT-1:0] req_wstrb,
  output logic [DATA_W*NPORT-1:0] req_rdata,
  output logic [NPORT-1:0]        req_ready,
  output logic                    memory_valid,
  output logic                    memory_instr,
  output logic [ADDR_W-1:0]       memory_addr,
  output logic [DATA_W-1:0]       memory_wdata,
  output logic [STRB_W-1:0]       memory_wstrb,
  input  logic [DATA_W-1:0]       memory_rdata,
  input  logic                    memory_ready,
  output logic                    busy,
  output logic [OWN_W-1:0]        owner
);

  typedef struct packed {
    state_e                      state;
    logic [OWN_W-1:0]            owner;
    req_t                        cur;
    req_t [NPORT-1:0]            latch;
    logic [NPORT-1:0][AGE_W-1:0] age;
  } regs_t;

  regs_t r_q, r_d;

  req_t [NPORT-1:0] eff_req;
  logic [NPORT-1:0] pending;
  logic [OWN_W-1:0] winner;
  logic             any_pending;
  logic             done;
  logic             grant_evt;
  logic             grant;
  req_t             win_req;
  req_t             mem_out;

  // A fresh request bypasses (and overrides) the latch in the cycle it arrives.
  always_comb begin : p_eff
    for (int i = 0; i < NPORT; i++) begin
      eff_req[i] = r_q.latch[i];
      if (req_valid[i]) begin
        eff_req[i].valid = 1'b1;
        eff_req[i].instr = req_instr[i];
        eff_req[i].addr  = req_addr[ADDR_W*i +: ADDR_W];
        eff_req[i].wdata = req_wdata[DATA_W*i +: DATA_W];
        eff_req[i].wstrb = req_wstrb[STRB_W*i +: STRB_W];
      end
      pending[i] = eff_req[i].valid;
    end
  end

  memory_scheduler_select #(
    .NPORT        (NPORT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .pending_i (pending),
    .age_i     (r_q.age),
    .winner_o  (winner),
    .any_o     (any_pending)
  );

  always_comb begin : p_win
    done      = (r_q.state == ST_BUSY) && memory_ready;
    grant_evt = (r_q.state == ST_IDLE) || done;
    grant     = grant_evt && any_pending;
    win_req   = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (winner == OWN_W'(i)) begin
        win_req = eff_req[i];
      end
    end
  end

  always_comb begin : p_next
    r_d = r_q;
    if (grant_evt) begin
      r_d.state = grant ? ST_BUSY : ST_IDLE;
      r_d.cur   = grant ? win_req : '0;
      if (grant) begin
        r_d.owner = winner;
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      if (grant && (winner == OWN_W'(i))) begin
        r_d.latch[i] = '0;
      end else if (req_valid[i]) begin
        r_d.latch[i] = eff_req[i];
      end
      // Ages only move at grant events; losers age, everyone else restarts at zero.
      if (grant_evt) begin
        if (pending[i] && !(grant && (winner == OWN_W'(i)))) begin
          r_d.age[i] = age_inc(r_q.age[i], AGE_W'(STARVE_LIMIT));
        end else begin
          r_d.age[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin : p_regs
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  // Memory side: held copy while waiting, otherwise the fresh winner.
  always_comb begin : p_mem
    mem_out = '0;
    if (!reset) begin
      if ((r_q.state == ST_BUSY) && !memory_ready) begin
        mem_out = r_q.cur;
      end else if (grant) begin
        mem_out = win_req;
      end
    end
  end

  assign memory_valid = mem_out.valid;
  assign memory_instr = mem_out.instr;
  assign memory_addr  = mem_out.addr;
  assign memory_wdata = mem_out.wdata;
  assign memory_wstrb = mem_out.wstrb;

  always_comb begin : p_resp
    req_ready = '0;
    req_rdata = '0;
    if (!reset && done) begin
      for (int i = 0; i < NPORT; i++) begin
        if (r_q.owner == OWN_W'(i)) begin
          req_ready[i]                    = 1'b1;
          req_rdata[DATA_W*i +: DATA_W] = memory_rdata;
        end
      end
    end
  end

  assign busy  = !reset && (r_q.state == ST_BUSY);
  assign owner = reset ? '0 : r_q.owner;

  // A requester may only re-request once its previous request has completed.
  for (genvar g = 0; g < NPORT; g++) begin : g_chk
    a_single_outstanding: assert property (@(posedge clock) disable iff (reset)
      !(req_valid[g] && (r_q.latch[g].valid ||
        ((r_q.state == ST_BUSY) && (r_q.owner == OWN_W'(g)) && !memory_ready))));
  end

endmodule

// File: tb/tb_memory_scheduler.sv
// Scoreboard bench for memory_scheduler: expected issues are queued with stimulus,
// a latency-programmable memory model answers them, and completions are checked per cycle.
module tb_memory_scheduler;

  localparam int NPORT = 3;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NPORT-1:0]      req_valid = '0;
  logic [NPORT-1:0]      req_instr = '0;
  logic [32*NPORT-1:0]   req_addr  = '0;
  logic [32*NPORT-1:0]   req_wdata = '0;
  logic [4*NPORT-1:0]    req_wstrb = '0;
  logic [32*NPORT-1:0]   req_rdata;
  logic [NPORT-1:0]      req_ready;
  logic                  memory_valid;
  logic                  memory_instr;
  logic [31:0]           memory_addr;
  logic [31:0]           memory_wdata;
  logic [3:0]            memory_wstrb;
  logic [31:0]           memory_rdata = '0;
  logic                  memory_ready = 1'b0;
  logic                  busy;
  logic [2:0]            owner;

  memory_scheduler #(.NPORT(NPORT), .STARVE_LIMIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_instr    (req_instr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_rdata    (req_rdata),
    .req_ready    (req_ready),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          port;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          at;
  } iss_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } cmp_t;

  iss_t        exp_q[$];
  cmp_t        cmp_q[$];
  iss_t        cur;
  bit          tb_out    = 1'b0;
  int          cnt       = 0;
  int          lat       = 1;
  int          exp_owner = 0;
  int          cyc_n     = 0;
  int          rereq0    = 0;
  logic [31:0] next0     = '0;
  int          n_tests   = 0;
  int          n_fail    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] addr);
    return (addr == 32'h100) ? 32'hDEADBEEF : ~addr;
  endfunction

  task automatic drive(input int port, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    req_valid[port]          = 1'b1;
    req_instr[port]          = instr;
    req_addr[32*port +: 32]  = addr;
    req_wdata[32*port +: 32] = wdata;
    req_wstrb[4*port +: 4]   = wstrb;
  endtask

  task automatic expect_issue(input int port, input logic instr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb, input int at);
    iss_t e;
    e.port = port; e.instr = instr; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic mon();
    logic [NPORT-1:0]    exp_rdy;
    logic [32*NPORT-1:0] exp_rd;
    bit                  completing;
    bit                  issue;
    cmp_t                c;
    iss_t                e;
    check("busy", 128'(busy), 128'(tb_out));
    check("owner", 128'(owner), 128'(exp_owner));
    exp_rdy    = '0;
    exp_rd     = '0;
    completing = tb_out && memory_ready;
    if (completing) begin
      if (cmp_q.size() == 0) begin
        check("spurious_completion", 128'(req_ready), 128'(0));
      end else begin
        c = cmp_q.pop_front();
        exp_rdy[c.port]          = 1'b1;
        exp_rd[32*c.port +: 32]  = c.rdata;
      end
    end
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    check("req_rdata", 128'(req_rdata), 128'(exp_rd));
    if (tb_out && !memory_ready) begin
      check("hold_valid", 128'(memory_valid), 128'(1));
      check("hold_addr", 128'(memory_addr), 128'(cur.addr));
      check("hold_wdata", 128'(memory_wdata), 128'(cur.wdata));
    end
    issue = memory_valid && (!tb_out || memory_ready);
    if (completing) tb_out = 1'b0;
    if (issue) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 128'(memory_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("issue_addr", 128'(memory_addr), 128'(e.addr));
        check("issue_instr", 128'(memory_instr), 128'(e.instr));
        check("issue_wdata", 128'(memory_wdata), 128'(e.wdata));
        check("issue_wstrb", 128'(memory_wstrb), 128'(e.wstrb));
        if (e.at >= 0) check("issue_cycle", 128'(cyc_n), 128'(e.at));
        cur       = e;
        tb_out    = 1'b1;
        cnt       = lat;
        exp_owner = e.port;
        c.port    = e.port;
        c.rdata   = rdata_of(e.addr);
        cmp_q.push_back(c);
      end
    end
  endtask

  // One clock cycle: memory model, re-request hook, settle, monitor, edge, clear pulses.
  task automatic cyc();
    memory_rdata = $urandom;
    if (tb_out) begin
      if (cnt <= 1) begin
        memory_ready = 1'b1;
        memory_rdata = rdata_of(cur.addr);
      end else begin
        cnt--;
      end
    end
    if (rereq0 > 0 && memory_ready && tb_out && cur.port == 0) begin
      drive(0, 1'b0, next0, 32'h0, 4'h0);
      next0  = next0 + 32'd4;
      rereq0--;
    end
    #2;
    mon();
    @(posedge clock);
    #1;
    req_valid    = '0;
    memory_ready = 1'b0;
    cyc_n++;
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tb_out) && k < max_cycles) begin
      cyc();
      k++;
    end
    if (exp_q.size() != 0 || tb_out) check("drain_timeout", 128'(exp_q.size() + int'(tb_out)), 128'(0));
  endtask

  // Reset for n cycles with a stray memory_ready asserted; everything must read zero.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      memory_ready = 1'b1;
      memory_rdata = 32'hFFFF_FFFF;
      #2;
      check("rst_mem_valid", 128'(memory_valid), 128'(0));
      check("rst_mem_addr", 128'(memory_addr), 128'(0));
      check("rst_req_ready", 128'(req_ready), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_owner", 128'(owner), 128'(0));
      @(posedge clock);
      #1;
      cyc_n++;
    end
    reset        = 1'b0;
    memory_ready = 1'b0;
    req_valid    = '0;
    tb_out       = 1'b0;
    exp_owner    = 0;
    rereq0       = 0;
    exp_q.delete();
    cmp_q.delete();
  endtask

  initial begin
    @(posedge clock);
    #1;
    do_reset(2);

    // Single read from port 1, three-cycle memory latency.
    lat = 3;
    expect_issue(1, 1'b0, 32'h100, 32'h0, 4'h0, cyc_n);
    drive(1, 1'b0, 32'h100, 32'h0, 4'h0);
    cyc();
    drain(30);

    // Stray memory_ready while idle.
    memory_ready = 1'b1;
    cyc();
    cyc();

    // All three ports at once: back-to-back issue in priority order.
    lat = 1;
    expect_issue(0, 1'b1, 32'h0000_0200, 32'h0,         4'h0, cyc_n);
    expect_issue(1, 1'b0, 32'h0000_0210, 32'h1122_3344, 4'hF, cyc_n + 1);
    expect_issue(2, 1'b0, 32'h0000_0220, 32'h5566_7788, 4'h3, cyc_n + 2);
    drive(0, 1'b1, 32'h0000_0200, 32'h0,         4'h0);
    drive(1, 1'b0, 32'h0000_0210, 32'h1122_3344, 4'hF);
    drive(2, 1'b0, 32'h0000_0220, 32'h5566_7788, 4'h3);
    cyc();
    drain(30);

    // Starvation: port 0 re-requests on every completion, port 2 wins the 5th grant.
    lat = 1;
    expect_issue(0, 1'b0, 32'h1000, 32'h0, 4'h0, cyc_n);
    expect_issue(0, 1'b0, 32'h1004, 32'h0, 4'h0, cyc_n + 1);
    expect_issue(0, 1'b0, 32'h1008, 32'h0, 4'h0, cyc_n + 2);
    expect_issue(0, 1'b0, 32'h100C, 32'h0, 4'h0, cyc_n + 3);
    expect_issue(2, 1'b0, 32'h2000, 32'h0, 4'h0, cyc_n + 4);
    expect_issue(0, 1'b0, 32'h1010, 32'h0, 4'h0, cyc_n + 5);
    drive(0, 1'b0, 32'h1000, 32'h0, 4'h0);
    drive(2, 1'b0, 32'h2000, 32'h0, 4'h0);
    rereq0 = 4;
    next0  = 32'h1004;
    cyc();
    drain(40);

    // Hold: long latency, port 0 arrives mid-transaction and issues on the completion cycle.
    lat = 10;
    expect_issue(1, 1'b0, 32'h300, 32'hCAFE_0001, 4'h1, cyc_n);
    expect_issue(0, 1'b1, 32'h400, 32'h0,         4'h0, cyc_n + 10);
    drive(1, 1'b0, 32'h300, 32'hCAFE_0001, 4'h1);
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    drive(0, 1'b1, 32'h400, 32'h0, 4'h0);
    cyc();
    drain(60);

    // Reset while busy with port 2 latched: nothing may issue or complete afterwards.
    lat = 10;
    expect_issue(1, 1'b0, 32'h500, 32'h0, 4'h0, cyc_n);
    drive(1, 1'b0, 32'h500, 32'h0, 4'h0);
    cyc();
    cyc();
    drive(2, 1'b0, 32'h600, 32'hBEEF_0002, 4'hC);
    cyc();
    do_reset(1);
    for (int i = 0; i < 5; i++) cyc();
    memory_ready = 1'b1;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1);
  end

endmodule

// File: doc/memory_scheduler.md
Name: memory_scheduler

Overview:
- Shares one single-outstanding memory port between NPORT requesters: instruction fetch, data, and debug/DMA (default 3).
- Each requester uses the core's valid/instr/addr/wdata/wstrb → rdata/ready handshake.
- Each port's request is latched. Arbitration is fixed priority (port 0 highest), with per-port aging so low-priority ports cannot starve.
- Sits between the core/debug masters and the memory/bus bridge.

Parameters:
- NPORT, 3, number of requesters (2..8).
- STARVE_LIMIT, 4, lost grant events before a pending port is promoted (1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NPORT  one-cycle request pulse per port
- req_instr  in  NPORT  instruction-fetch flag per port
- req_addr  in  32*NPORT  address, port i at [32i+31:32i]
- req_wdata  in  32*NPORT  write data
- req_wstrb  in  4*NPORT  byte strobes; 0 means read
- req_rdata  out  32*NPORT  read data, valid only with req_ready
- req_ready  out  NPORT  one-cycle completion pulse per port
- memory_valid  out  1  request to memory, held until memory_ready
- memory_instr  out  1
- memory_addr  out  32
- memory_wdata  out  32
- memory_wstrb  out  4
- memory_rdata  in  32
- memory_ready  in  1  completion pulse
- busy  out  1  transaction outstanding
- owner  out  3  index of the current/last granted port

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - All latches empty, all ages 0, state IDLE, owner 0.
  - All outputs 0 during and after reset until a new grant.
  - Any outstanding transaction is abandoned. A memory_ready arriving after reset while IDLE is ignored.
- Latch: per port, holds valid/instr/addr/wdata/wstrb.
  - Loaded when req_valid[i]=1.
  - A requester must not pulse valid again before its req_ready. Violating this is an assertion failure; RTL overwrites the latch.
- Effective pending[i] = latch[i].valid OR req_valid[i] (same-cycle bypass).
- State IDLE:
  - If any pending: select winner, drive memory_* combinationally from the winner (zero-cycle issue latency), set owner, clear winner's latch, go BUSY.
  - Otherwise memory_* = 0.
- State BUSY:
  - memory_* are held from registered copies, stable every cycle until memory_ready.
  - On memory_ready: req_ready[owner]=1 and req_rdata[owner]=memory_rdata in the same cycle. All other ready/rdata are 0.
  - In that same cycle the scheduler arbitrates again as in IDLE (back-to-back issue, no bubble).
- memory_ready while IDLE: ignored, no req_ready.
- Winner selection:
  - Lowest index i with age[i]==STARVE_LIMIT.
  - Otherwise lowest index pending.
- Aging:
  - At each grant event, every pending non-winner port increments its age, saturating at STARVE_LIMIT.
  - The winner's age resets to 0.
  - A non-pending port's age is 0.
- Simultaneous events:
  - req_valid[i] in the same cycle as memory_ready for port i's previous transaction is legal. The new request is latched or bypassed normally.
  - Multiple ports valid in one cycle are all latched; one is granted.
- busy = state BUSY. owner holds its last value while IDLE.

Decomposition:
- Package (constants): state enum (IDLE, BUSY) and a request struct {valid, instr, addr[31:0], wdata[31:0], wstrb[3:0]}.
- Sub-module: memory_scheduler_select (combinational: pending, ages → winner index, any). All registers stay in the top in a single r/rin record.

Test Plan:
- Single read: port1 valid, addr 0x100, wstrb 0 → memory_valid same cycle, memory_addr 0x100. memory_ready after 3 cycles with rdata 0xDEADBEEF → req_ready[1]=1, req_rdata port1 0xDEADBEEF, other ready 0.
- Simultaneous: ports 0,1,2 valid in one cycle, memory_ready 1 cycle after each issue → issue order 0,1,2 back-to-back with no idle cycle; three req_ready pulses.
- Starvation (STARVE_LIMIT=4): port0 re-requests every completion, port2 pending from start → port2 granted on the 5th grant; its age was 4.
- Hold/stability: memory_ready delayed 10 cycles, new port0 valid arrives mid-transaction → memory_addr unchanged for all 10 cycles; port0 issued in the completion cycle.
- Stray ready: memory_ready=1 while IDLE → no req_ready, busy stays 0.
- Reset mid-transaction: assert reset while BUSY with port2 latched → next cycle all outputs 0 and latches empty; a later memory_ready produces no req_ready.
